// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered read ports, write-first bypass and a hardware clear sequencer.
// Optional per-entry even parity with error injection is enabled by defining REG_FILE_PARITY_EN.
module reg_file_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEn_A,
  input  logic [ADDR_W-1:0] RdAddr_A,
  output logic [WIDTH-1:0]  RdData_A,
  output logic              RdValid_A,
  input  logic              RdEn_B,
  input  logic [ADDR_W-1:0] RdAddr_B,
  output logic [WIDTH-1:0]  RdData_B,
  output logic              RdValid_B,
  input  logic              ClrReq,
`ifdef REG_FILE_PARITY_EN
  input  logic              ParInj,
  output logic              RdParErr_A,
  output logic              RdParErr_B,
`endif
  output logic              ClrBusy
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  // One extra address bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_clrCnt;
  logic [ADDR_W-1:0] w_nextCnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic [WIDTH-1:0]  r_rdDataA;
  logic [WIDTH-1:0]  r_rdDataB;
  logic              r_rdValidA;
  logic              r_rdValidB;
  logic [WIDTH-1:0]  w_rdDataA;
  logic [WIDTH-1:0]  w_rdDataB;

  logic w_clrActive;
  logic w_wrCommit;

  assign w_clrActive = (r_state == S_CLEAR);
  assign w_wrCommit  = WrEn && (r_state == S_IDLE) && ({1'b0, WrAddr} < DEPTH_EXT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_clrCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_clrCnt <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_clrCnt;
    case (r_state)
      S_IDLE: begin
        if (ClrReq) begin
          w_nextState = S_CLEAR;
          w_nextCnt   = '0;
        end
      end
      S_CLEAR: begin
        if (r_clrCnt == LAST_IDX) begin
          w_nextState = S_IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_clrCnt + ADDR_W'(1);
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // A user write only commits in IDLE, so it can never collide with a clear write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clrActive) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_wrCommit) begin
      r_mem[WrAddr] <= WrData;
    end
  end

  always_comb begin
    w_rdDataA = '0;
    if (w_wrCommit && (WrAddr == RdAddr_A)) begin
      w_rdDataA = WrData;
    end else if (w_clrActive && (r_clrCnt == RdAddr_A)) begin
      w_rdDataA = '0;
    end else if ({1'b0, RdAddr_A} < DEPTH_EXT) begin
      w_rdDataA = r_mem[RdAddr_A];
    end
  end

  always_comb begin
    w_rdDataB = '0;
    if (w_wrCommit && (WrAddr == RdAddr_B)) begin
      w_rdDataB = WrData;
    end else if (w_clrActive && (r_clrCnt == RdAddr_B)) begin
      w_rdDataB = '0;
    end else if ({1'b0, RdAddr_B} < DEPTH_EXT) begin
      w_rdDataB = r_mem[RdAddr_B];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rdDataA  <= '0;
      r_rdDataB  <= '0;
      r_rdValidA <= 1'b0;
      r_rdValidB <= 1'b0;
    end else begin
      r_rdValidA <= RdEn_A;
      r_rdValidB <= RdEn_B;
      if (RdEn_A) r_rdDataA <= w_rdDataA;
      if (RdEn_B) r_rdDataB <= w_rdDataB;
    end
  end

  assign RdData_A  = r_rdDataA;
  assign RdData_B  = r_rdDataB;
  assign RdValid_A = r_rdValidA;
  assign RdValid_B = r_rdValidB;
  assign ClrBusy   = w_clrActive;

`ifdef REG_FILE_PARITY_EN
  // Stored bit is even parity of the data, optionally inverted to inject an error.
  logic [DEPTH-1:0] r_par;
  logic             w_wrPar;
  logic             w_rdParA;
  logic             w_rdParB;
  logic             r_parErrA;
  logic             r_parErrB;

  assign w_wrPar = (^WrData) ^ ParInj;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par <= '0;
    end else if (w_clrActive) begin
      r_par[r_clrCnt] <= 1'b0;
    end else if (w_wrCommit) begin
      r_par[WrAddr] <= w_wrPar;
    end
  end

  always_comb begin
    w_rdParA = 1'b0;
    w_rdParB = 1'b0;
    if (w_wrCommit && (WrAddr == RdAddr_A)) begin
      w_rdParA = w_wrPar;
    end else if (w_clrActive && (r_clrCnt == RdAddr_A)) begin
      w_rdParA = 1'b0;
    end else if ({1'b0, RdAddr_A} < DEPTH_EXT) begin
      w_rdParA = r_par[RdAddr_A];
    end
    if (w_wrCommit && (WrAddr == RdAddr_B)) begin
      w_rdParB = w_wrPar;
    end else if (w_clrActive && (r_clrCnt == RdAddr_B)) begin
      w_rdParB = 1'b0;
    end else if ({1'b0, RdAddr_B} < DEPTH_EXT) begin
      w_rdParB = r_par[RdAddr_B];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_parErrA <= 1'b0;
      r_parErrB <= 1'b0;
    end else begin
      r_parErrA <= RdEn_A && ((^w_rdDataA) != w_rdParA);
      r_parErrB <= RdEn_B && ((^w_rdDataB) != w_rdParB);
    end
  end

  assign RdParErr_A = r_parErrA;
  assign RdParErr_B = r_parErrB;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: vector table for basic reads/writes/bypass, plus
// hand-written sequences for out-of-range access, clear sequencing, mid-clear reset and parity.
module tb_reg_file_2r1w;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WrEn = 1'b0;
  logic [2:0]  WrAddr = '0;
  logic [15:0] WrData = '0;
  logic        RdEn_A = 1'b0;
  logic [2:0]  RdAddr_A = '0;
  logic        RdEn_B = 1'b0;
  logic [2:0]  RdAddr_B = '0;
  logic        ClrReq = 1'b0;

  logic [15:0] RdData_A, RdData_B, sRdData_A, sRdData_B;
  logic        RdValid_A, RdValid_B, sRdValid_A, sRdValid_B;
  logic        ClrBusy, sClrBusy;

`ifdef REG_FILE_PARITY_EN
  logic ParInj = 1'b0;
  logic RdParErr_A, RdParErr_B, sRdParErr_A, sRdParErr_B;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic        rdEnA;
    logic [2:0]  addrA;
    logic        rdEnB;
    logic [2:0]  addrB;
    logic [15:0] expA;
    logic        expVA;
    logic [15:0] expB;
    logic        expVB;
  } vec_t;

  vec_t vecs [10];

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u_dut (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(RdData_A), .RdValid_A(RdValid_A),
    .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(RdData_B), .RdValid_B(RdValid_B),
    .ClrReq(ClrReq),
`ifdef REG_FILE_PARITY_EN
    .ParInj(ParInj), .RdParErr_A(RdParErr_A), .RdParErr_B(RdParErr_B),
`endif
    .ClrBusy(ClrBusy)
  );

  // Six-entry instance shares all inputs; used to exercise addresses beyond DEPTH.
  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) u_dut6 (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn_A(RdEn_A), .RdAddr_A(RdAddr_A), .RdData_A(sRdData_A), .RdValid_A(sRdValid_A),
    .RdEn_B(RdEn_B), .RdAddr_B(RdAddr_B), .RdData_B(sRdData_B), .RdValid_B(sRdValid_B),
    .ClrReq(ClrReq),
`ifdef REG_FILE_PARITY_EN
    .ParInj(ParInj), .RdParErr_A(sRdParErr_A), .RdParErr_B(sRdParErr_B),
`endif
    .ClrBusy(sClrBusy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    WrEn   = 1'b0;
    RdEn_A = 1'b0;
    RdEn_B = 1'b0;
    ClrReq = 1'b0;
`ifdef REG_FILE_PARITY_EN
    ParInj = 1'b0;
`endif
  endtask

  task automatic applyStimulus(input vec_t v);
    WrEn     = v.wrEn;
    WrAddr   = v.wrAddr;
    WrData   = v.wrData;
    RdEn_A   = v.rdEnA;
    RdAddr_A = v.addrA;
    RdEn_B   = v.rdEnB;
    RdAddr_B = v.addrB;
    ClrReq   = 1'b0;
  endtask

  task automatic writeWord(input logic [2:0] addr, input logic [15:0] data);
    WrEn = 1'b1;
    WrAddr = addr;
    WrData = data;
    tick();
    idleInputs();
  endtask

  task automatic readA(input string name, input logic [2:0] addr, input logic [15:0] expected);
    RdEn_A = 1'b1;
    RdAddr_A = addr;
    tick();
    idleInputs();
    checkOutput(name, RdData_A, expected);
    checkOutput({name, "Valid"}, 16'(RdValid_A), 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           wrEn wA  wData     rA  aA  rB  aB  expA     vA  expB     vB
    vecs[0] = '{1'b1, 3'd5, 16'h000B, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0, 16'h000B, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h000B, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 16'h001F, 1'b0, 3'd0, 1'b0, 3'd0, 16'h000B, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 3'd7, 16'hA5A5, 1'b0, 3'd0, 1'b0, 3'd0, 16'h000B, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd7, 16'h001F, 1'b1, 16'hA5A5, 1'b1};
    vecs[6] = '{1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 1'b1, 3'd3, 16'h1234, 1'b1, 16'h1234, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h1234, 1'b1};
    vecs[8] = '{1'b1, 3'd0, 16'hBEEF, 1'b1, 3'd0, 1'b1, 3'd5, 16'hBEEF, 1'b1, 16'h000B, 1'b1};
    vecs[9] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h000B, 1'b0};

    idleInputs();
    #3;
    checkOutput("rstDataA", RdData_A, 16'h0000);
    checkOutput("rstValidA", 16'(RdValid_A), 16'd0);
    checkOutput("rstDataB", RdData_B, 16'h0000);
    checkOutput("rstValidB", 16'(RdValid_B), 16'd0);
    checkOutput("rstBusy", 16'(ClrBusy), 16'd0);
    #4;
    RST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      idleInputs();
      checkOutput($sformatf("vec%0d_dataA", i), RdData_A, vecs[i].expA);
      checkOutput($sformatf("vec%0d_validA", i), 16'(RdValid_A), 16'(vecs[i].expVA));
      checkOutput($sformatf("vec%0d_dataB", i), RdData_B, vecs[i].expB);
      checkOutput($sformatf("vec%0d_validB", i), 16'(RdValid_B), 16'(vecs[i].expVB));
    end

    // Out-of-range: addr 7 was never stored in the six-entry instance.
    RdEn_A = 1'b1; RdAddr_A = 3'd5;
    RdEn_B = 1'b1; RdAddr_B = 3'd7;
    tick();
    idleInputs();
    checkOutput("oorMainB", RdData_B, 16'hA5A5);
    checkOutput("oorSmallA", sRdData_A, 16'h000B);
    checkOutput("oorSmallB", sRdData_B, 16'h0000);
    checkOutput("oorSmallValidB", 16'(sRdValid_B), 16'd1);

    WrEn = 1'b1; WrAddr = 3'd6; WrData = 16'h7777;
    RdEn_A = 1'b1; RdAddr_A = 3'd6;
    tick();
    idleInputs();
    checkOutput("oorBypassMain", RdData_A, 16'h7777);
    checkOutput("oorBypassSmall", sRdData_A, 16'h0000);
    checkOutput("oorBypassSmallValid", 16'(sRdValid_A), 16'd1);

    // Clear sequence: busy for exactly eight samples, writes dropped, clear-write bypass.
    for (int a = 0; a < 8; a++) writeWord(3'(a), 16'h1111 * 16'(a + 1));
    ClrReq = 1'b1;
    tick();
    idleInputs();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("clrBusyHigh%0d", i), 16'(ClrBusy), 16'd1);
      if (i == 2) ClrReq = 1'b1;
      if (i == 3) begin
        RdEn_A = 1'b1; RdAddr_A = 3'd3;
        RdEn_B = 1'b1; RdAddr_B = 3'd4;
      end
      if (i == 6) begin
        WrEn = 1'b1; WrAddr = 3'd0; WrData = 16'hFFFF;
      end
      tick();
      idleInputs();
      if (i == 3) begin
        checkOutput("clrBypassA", RdData_A, 16'h0000);
        checkOutput("clrBypassValidA", 16'(RdValid_A), 16'd1);
        checkOutput("clrOldB", RdData_B, 16'h5555);
      end
    end
    checkOutput("clrBusyLow", 16'(ClrBusy), 16'd0);
    for (int a = 0; a < 8; a++) readA($sformatf("clrRead%0d", a), 3'(a), 16'h0000);

    // Write and clear request on the same edge: write lands, then gets cleared.
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'h3333; ClrReq = 1'b1;
    tick();
    idleInputs();
    readA("wrClrCommit", 3'd2, 16'h3333);
    for (int k = 0; k < 20 && ClrBusy; k++) tick();
    checkOutput("wrClrDone", 16'(ClrBusy), 16'd0);
    readA("wrClrZeroed", 3'd2, 16'h0000);

    // Reset asserted in the middle of a clear.
    for (int a = 0; a < 8; a++) writeWord(3'(a), 16'h1111 * 16'(a + 1));
    ClrReq = 1'b1;
    tick();
    idleInputs();
    tick();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    RdEn_A = 1'b1; RdAddr_A = 3'd7;
    tick();
    idleInputs();
    checkOutput("midClrPreA", RdData_A, 16'h8888);
    RST = 1'b0;
    #1;
    checkOutput("midRstDataA", RdData_A, 16'h0000);
    checkOutput("midRstValidA", 16'(RdValid_A), 16'd0);
    checkOutput("midRstBusy", 16'(ClrBusy), 16'd0);
    #2;
    RST = 1'b1;
    for (int a = 0; a < 8; a++) readA($sformatf("midRstRead%0d", a), 3'(a), 16'h0000);
    writeWord(3'd6, 16'h4242);
    readA("postRstRead", 3'd6, 16'h4242);

`ifdef REG_FILE_PARITY_EN
    WrEn = 1'b1; WrAddr = 3'd1; WrData = 16'h0001; ParInj = 1'b1;
    tick();
    idleInputs();
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 16'h0003;
    tick();
    idleInputs();
    RdEn_A = 1'b1; RdAddr_A = 3'd1;
    tick();
    idleInputs();
    checkOutput("parErrInjected", 16'(RdParErr_A), 16'd1);
    RdEn_A = 1'b1; RdAddr_A = 3'd4;
    tick();
    idleInputs();
    checkOutput("parErrClean", 16'(RdParErr_A), 16'd0);
    tick();
    checkOutput("parErrIdle", 16'(RdParErr_A), 16'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
